pit_burst_engine: RTL



---
 rtl/pit_burst_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pit_burst_engine.sv
// rtl/pit_burst_engine.sv - PIT burst sequencer between name lookup and single-port content memory
module pit_burst_engine #(
    parameter int ADDR_W    = 62,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W:0]   table_entry,
    input  logic              in_bit,
    input  logic              out_bit,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              write_enable,
    output logic              start_bit,
    output logic              fib_out,
    output logic              busy,
    output logic              done,
    output logic              wrap_err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, READ, TAIL} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                wrap_pend, wrap_pend_n;
    logic                step;

    logic [ADDR_W-1:0]   address_n;
    logic [DATA_W-1:0]   out_data_n;
    logic                out_valid_n, write_enable_n, start_bit_n;
    logic                fib_out_n, done_n, wrap_err_n;

    logic                hit;
    logic [ADDR_W-1:0]   base;

    assign hit  = table_entry[ADDR_W];
    assign base = table_entry[ADDR_W-1:0];

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        cnt_n          = cnt;
        step           = 1'b0;
        wrap_pend_n    = 1'b0;
        address_n      = address;
        out_data_n     = out_data;
        out_valid_n    = 1'b0;
        write_enable_n = 1'b0;
        start_bit_n    = start_bit;
        fib_out_n      = 1'b0;
        done_n         = 1'b0;
        // A wrap is flagged the cycle after the increment, which lines it up with address 0.
        wrap_err_n     = wrap_pend;

        case (state)
            IDLE: begin
                if (in_bit) begin
                    ptr_n       = base;
                    cnt_n       = '0;
                    start_bit_n = 1'b1;
                    state_n     = WRITE;
                end else if (out_bit) begin
                    state_n = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ptr_n   = base;
                    cnt_n   = '0;
                    state_n = READ;
                end else begin
                    fib_out_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            WRITE: begin
                if (cnt == FULL_CNT) begin
                    start_bit_n = 1'b0;
                    done_n      = 1'b1;
                    state_n     = IDLE;
                end else if (in_valid) begin
                    address_n      = ptr;
                    out_data_n     = in_data;
                    write_enable_n = 1'b1;
                    step           = 1'b1;
                    cnt_n          = cnt + CNT_W'(1);
                end
            end
            READ: begin
                address_n = ptr;
                step      = 1'b1;
                cnt_n     = cnt + CNT_W'(1);
                // Memory data lags the address by one cycle, so the first READ cycle has no beat.
                if (cnt != '0) begin
                    out_data_n  = read_data;
                    out_valid_n = 1'b1;
                end
                if (cnt == LAST_ISSUE) begin
                    state_n = TAIL;
                end
            end
            TAIL: begin
                out_data_n  = read_data;
                out_valid_n = 1'b1;
                done_n      = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (step) begin
            ptr_n       = ptr + ADDR_W'(1);
            wrap_pend_n = &ptr;
        end
    end

    // State, pointer/counter and registered outputs; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            wrap_pend    <= 1'b0;
            address      <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            write_enable <= 1'b0;
            start_bit    <= 1'b0;
            fib_out      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wrap_err     <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            wrap_pend    <= wrap_pend_n;
            address      <= address_n;
            out_data     <= out_data_n;
            out_valid    <= out_valid_n;
            write_enable <= write_enable_n;
            start_bit    <= start_bit_n;
            fib_out      <= fib_out_n;
            busy         <= (state_n != IDLE);
            done         <= done_n;
            wrap_err     <= wrap_err_n;
        end
    end

endmodule
